// File: rtl/gearbox_frame_arbiter_pkg.sv
// Shared constants and state encoding for the frame-granular gearbox arbiter.
package gb_arb_pkg;

  localparam int BLK_PER_FRAME = 32;
  localparam int DIN_W         = 132;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2
  } gb_state_e;

endpackage

// File: rtl/gearbox_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] idx_s;
  logic            hit_s;

  // Walk all NUM_REQ positions once, starting one past the previous owner.
  always_comb begin
    found = 1'b0;
    id    = '0;
    idx_s = last;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (idx_s == ID_W'(NUM_REQ - 1)) ? '0 : idx_s + ID_W'(1);
      hit_s = !found && req[idx_s];
      found = found | hit_s;
      id    = hit_s ? idx_s : id;
    end
  end

endmodule

// File: rtl/gearbox_frame_arbiter.sv
// Grants the shared 132->128 gearbox to one source per 32-block frame so no
// output word ever mixes two sources; drains across the gearbox pause cycle.
module gearbox_frame_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIN_W   = gb_arb_pkg::DIN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     gb_din_valid,
  output logic [DIN_W-1:0]         gb_din,
  input  logic                     gb_din_ready,
  output logic                     gnt_active,
  output logic [ID_W-1:0]          gnt_id,
  output logic [4:0]               blk_cnt,
  output logic                     frame_done
);
  import gb_arb_pkg::*;

  gb_state_e       state_r, state_nxt_s;
  logic [4:0]      blk_cnt_r;
  logic [ID_W-1:0] last_gnt_r, gnt_id_r, pick_id_s;
  logic            pick_found_s, accept_s;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
    .req   (req_valid),
    .last  (last_gnt_r),
    .found (pick_found_s),
    .id    (pick_id_s)
  );

  // Next-state and output decode; the owner mux in LOCKED is the only input path.
  always_comb begin
    state_nxt_s  = state_r;
    req_ready    = '0;
    gb_din_valid = 1'b0;
    gb_din       = '0;
    gnt_active   = 1'b0;
    frame_done   = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) state_nxt_s = LOCKED;
        else              state_nxt_s = IDLE;
      end
      LOCKED: begin
        gnt_active          = 1'b1;
        gb_din              = req_data[int'(gnt_id_r)*DIN_W +: DIN_W];
        gb_din_valid        = req_valid[gnt_id_r];
        req_ready[gnt_id_r] = gb_din_ready;
        accept_s            = req_valid[gnt_id_r] & gb_din_ready;
        // Owner bubbles keep the lock; only the 32nd accept ends the frame.
        if (accept_s && (blk_cnt_r == 5'(BLK_PER_FRAME - 1))) begin
          frame_done  = 1'b1;
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      DRAIN: begin
        gnt_active = 1'b1;
        if (gb_din_ready) state_nxt_s = IDLE;
        else              state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, frame counter and grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      blk_cnt_r  <= 5'd0;
      last_gnt_r <= ID_W'(NUM_REQ - 1);
      gnt_id_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && pick_found_s) gnt_id_r <= pick_id_s;
      if (accept_s) blk_cnt_r <= blk_cnt_r + 5'd1;
      if (frame_done) last_gnt_r <= gnt_id_r;
    end
  end

  assign gnt_id  = gnt_id_r;
  assign blk_cnt = blk_cnt_r;

endmodule

// File: tb/tb_gearbox_frame_arbiter.sv
// Directed self-checking bench for gearbox_frame_arbiter; every source carries
// a distinct tag in its top byte so gearbox input purity can be verified.
module tb_gearbox_frame_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DIN_W   = 132;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DIN_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     gb_din_valid;
  logic [DIN_W-1:0]         gb_din;
  logic                     gb_din_ready;
  logic                     gnt_active;
  logic [ID_W-1:0]          gnt_id;
  logic [4:0]               blk_cnt;
  logic                     frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  gearbox_frame_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN_W(DIN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .gb_din_valid (gb_din_valid),
    .gb_din       (gb_din),
    .gb_din_ready (gb_din_ready),
    .gnt_active   (gnt_active),
    .gnt_id       (gnt_id),
    .blk_cnt      (blk_cnt),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner `owner` is locked with blk_cnt == first; run through the 32nd accept.
  task automatic run_blocks(input int owner, input int first);
    for (int k = first; k < 32; k++) begin
      check("own_id",    32'(gnt_id),           32'(owner));
      check("own_ready", 32'(req_ready),        32'(1 << owner));
      check("own_valid", 32'(gb_din_valid),     32'(1));
      check("own_cnt",   32'(blk_cnt),          32'(k));
      check("own_done",  32'(frame_done),       32'(k == 31));
      check("own_tag",   32'(gb_din[131:124]),  32'(8'hA0 + owner));
      tick();
    end
  endtask

  // One DRAIN cycle with the gearbox ready, then one IDLE cycle.
  task automatic tail(input int owner);
    check("drain_active", 32'(gnt_active),   32'(1));
    check("drain_id",     32'(gnt_id),       32'(owner));
    check("drain_valid",  32'(gb_din_valid), 32'(0));
    check("drain_ready",  32'(req_ready),    32'(0));
    check("drain_cnt",    32'(blk_cnt),      32'(0));
    tick();
    check("idle_active",  32'(gnt_active),   32'(0));
    check("idle_ready",   32'(req_ready),    32'(0));
    check("idle_valid",   32'(gb_din_valid), 32'(0));
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 4'b0000;
    gb_din_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      req_data[i*DIN_W +: DIN_W] = {8'(8'hA0 + i), 124'(i * 7 + 1)};
    tick();
    tick();

    check("rst_active", 32'(gnt_active),     32'(0));
    check("rst_ready",  32'(req_ready),      32'(0));
    check("rst_valid",  32'(gb_din_valid),   32'(0));
    check("rst_cnt",    32'(blk_cnt),        32'(0));
    check("rst_id",     32'(gnt_id),         32'(0));
    check("rst_done",   32'(frame_done),     32'(0));
    check("rst_din",    32'(gb_din != '0),   32'(0));

    // Lone requester 2: grant one cycle later, 32 accepts, drain, idle, re-grant.
    rst       = 1'b0;
    req_valid = 4'b0100;
    tick();
    check("t1_grant",  32'(gnt_id),     32'(2));
    check("t1_active", 32'(gnt_active), 32'(1));
    run_blocks(2, 0);
    tail(2);
    check("t1_regrant", 32'(gnt_id),     32'(2));
    check("t1_reactive", 32'(gnt_active), 32'(1));

    // Mid-frame reset at blk_cnt 17; arbitration then restarts at requester 0.
    for (int k = 0; k < 17; k++) tick();
    check("t5_pre_cnt", 32'(blk_cnt), 32'(17));
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("t5_active", 32'(gnt_active),   32'(0));
    check("t5_cnt",    32'(blk_cnt),      32'(0));
    check("t5_ready",  32'(req_ready),    32'(0));
    check("t5_valid",  32'(gb_din_valid), 32'(0));
    tick();
    rst = 1'b0;
    tick();
    check("t5_restart", 32'(gnt_id), 32'(0));

    // All four valid: frames in order 0,1,2,3,0.
    run_blocks(0, 0); tail(0);
    run_blocks(1, 0); tail(1);
    run_blocks(2, 0); tail(2);
    run_blocks(3, 0); tail(3);
    check("t2_wrap", 32'(gnt_id), 32'(0));
    run_blocks(0, 0); tail(0);

    // Owner 1 stalls after 10 blocks while requester 3 waits.
    check("t3_owner", 32'(gnt_id), 32'(1));
    req_valid = 4'b1010;
    for (int k = 0; k < 10; k++) tick();
    check("t3_cnt10", 32'(blk_cnt), 32'(10));
    req_valid = 4'b1000;
    for (int k = 0; k < 50; k++) begin
      tick();
      check("t3_hold_cnt", 32'(blk_cnt),      32'(10));
      check("t3_hold_id",  32'(gnt_id),       32'(1));
      check("t3_ready3",   32'(req_ready[3]), 32'(0));
      check("t3_valid",    32'(gb_din_valid), 32'(0));
    end
    req_valid = 4'b1010;
    #1;
    run_blocks(1, 10);

    // Downstream backpressure: gearbox not ready for 5 cycles after the 32nd accept.
    gb_din_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_drain_active", 32'(gnt_active),   32'(1));
      check("t4_drain_valid",  32'(gb_din_valid), 32'(0));
      check("t4_drain_ready",  32'(req_ready),    32'(0));
      tick();
    end
    check("t4_still_drain", 32'(gnt_active), 32'(1));
    check("t4_drain_id",    32'(gnt_id),     32'(1));
    gb_din_ready = 1'b1;
    tick();
    check("t4_idle", 32'(gnt_active), 32'(0));
    tick();
    check("t4_next",   32'(gnt_id),     32'(3));
    check("t4_active", 32'(gnt_active), 32'(1));
    run_blocks(3, 0);
    tail(3);
    check("t4_after", 32'(gnt_id), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
